// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared period constants and width helpers for the tick generator
package clk_div_multi_pkg;

    localparam int DIV_1KHZ  = 50000;
    localparam int DIV_100HZ = 500000;  // needs W >= 19

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel-select width, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/pending period, square wave and tick
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEFAULT_DIV = DIV_1KHZ
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_div_i,
    output logic         clk_o,
    output logic         tick_o,
    output logic         pend_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         last;
    logic         wrap;
    logic         apply;
    logic [W-1:0] thr;

    always_comb begin
        last       = (div_q != '0) && (cnt_q == div_q - W'(1));
        wrap       = en_i && last;
        apply      = pend_q && (sync_i || wrap || (div_q == '0));

        cnt_d      = cnt_q;
        if (sync_i || (div_q == '0)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end

        div_d      = apply ? pend_div_q : div_q;
        pend_div_d = wr_i ? wr_div_i : pend_div_q;
        // A write landing on the wrap edge re-arms pend instead of being consumed.
        pend_d     = wr_i ? 1'b1 : (apply ? 1'b0 : pend_q);

        // Square wave is registered from next-state values so it tracks cnt with no lag.
        thr        = div_d - (div_d >> 1);
        clk_d      = (div_d != '0) && (cnt_d >= thr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = wrap && !sync_i;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable tick generator: write decode and channel fan-out
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int W           = 16,
    parameter int DEFAULT_DIV = DIV_1KHZ,
    localparam int CW         = sel_width(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_div,
    output logic [NCH-1:0] clk_o,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] pend_o
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr;
        // Out-of-range channel numbers match no instance, so those writes fall away.
        assign wr = cfg_we && (cfg_ch == CW'(i));

        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en_i     (en),
            .sync_i   (sync),
            .wr_i     (wr),
            .wr_div_i (cfg_div),
            .clk_o    (clk_o[i]),
            .tick_o   (tick_o[i]),
            .pend_o   (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sync;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [4:0]  clk_o;
    logic [4:0]  tick_o;
    logic [4:0]  pend_o;

    int          checks = 0;
    int          errors = 0;
    int          ntick;
    int          tick_at;
    int          bad;
    logic [4:0]  tick_val, clk_lo, clk_hi, pend_mid, acc;
    logic [11:0] cseq, tseq;

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(5), .W(16), .DEFAULT_DIV(50000)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .clk_o   (clk_o),
        .tick_o  (tick_o),
        .pend_o  (pend_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic we, input logic [2:0] ch, input logic [15:0] dv);
        cfg_we  = we;
        cfg_ch  = ch;
        cfg_div = dv;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sync = 1'b0;
        cfg(1'b0, 3'd0, 16'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_clk", 32'(clk_o), 32'h0);
        chk("rst_tick", 32'(tick_o), 32'h0);
        chk("rst_pend", 32'(pend_o), 32'h0);

        // Default period: one tick per 50000 cycles; ch1=4 written late in the period.
        @(negedge clk);
        reset = 1'b0; en = 1'b1;
        ntick = 0; tick_at = -1; tick_val = '0;
        clk_lo = 'x; clk_hi = 'x; pend_mid = 'x;
        for (int c = 0; c < 50000; c++) begin
            if (c == 49990) cfg(1'b1, 3'd1, 16'd4);
            else            cfg(1'b0, 3'd0, 16'd0);
            #1;
            if (tick_o != 5'h0) begin
                ntick++; tick_at = c; tick_val = tick_o;
            end
            if (c == 24999) clk_lo = clk_o;
            if (c == 25000) clk_hi = clk_o;
            if (c == 49995) pend_mid = pend_o;
            @(negedge clk);
        end
        chk("def_ntick", 32'(ntick), 32'd1);
        chk("def_tick_at", 32'(tick_at), 32'd49999);
        chk("def_tick_all", 32'(tick_val), 32'h1f);
        chk("def_clk_lo", 32'(clk_lo), 32'h0);
        chk("def_clk_hi", 32'(clk_hi), 32'h1f);
        chk("ch1_pend_wait", 32'(pend_mid), 32'h02);

        cseq = '0; tseq = '0;
        for (int r = 0; r < 12; r++) begin
            #1;
            if (r == 0) chk("ch1_pend_clr", 32'(pend_o), 32'h0);
            cseq = {cseq[10:0], clk_o[1]};
            tseq = {tseq[10:0], tick_o[1]};
            @(negedge clk);
        end
        chk("ch1_clk_seq", 32'(cseq), 32'h333);
        chk("ch1_tick_seq", 32'(tseq), 32'h111);

        // ch2: last write wins, applied by sync; then disabled.
        cfg(1'b1, 3'd2, 16'd5);
        @(negedge clk);
        cfg(1'b1, 3'd2, 16'd3);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        #1;
        chk("ch2_pend", 32'(pend_o), 32'h04);
        @(negedge clk);
        sync = 1'b1;
        #1;
        chk("sync1_tick", 32'(tick_o), 32'h0);
        @(negedge clk);
        sync = 1'b0;
        #1;
        chk("sync1_pend", 32'(pend_o), 32'h0);
        cseq = '0; tseq = '0;
        for (int s = 0; s < 9; s++) begin
            #1;
            cseq = {cseq[10:0], clk_o[2]};
            tseq = {tseq[10:0], tick_o[2]};
            @(negedge clk);
        end
        chk("ch2_clk_seq", 32'(cseq), 32'h049);
        chk("ch2_tick_seq", 32'(tseq), 32'h049);
        cfg(1'b1, 3'd2, 16'd0);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        #1;
        chk("ch2_off_pend", 32'(pend_o[2]), 32'h1);
        @(negedge clk);
        #1;
        chk("ch2_last_tick", 32'(tick_o[2]), 32'h1);
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            acc = acc | {2'b0, clk_o[2], tick_o[2], pend_o[2]};
        end
        chk("ch2_disabled", 32'(acc), 32'h0);

        // ch0: P=4, then 7 written in the exact wrap cycle.
        @(negedge clk);
        cfg(1'b1, 3'd0, 16'd4);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        repeat (3) @(negedge clk);
        cfg(1'b1, 3'd0, 16'd7);
        #1;
        chk("ch0_wrap_tick", 32'(tick_o[0]), 32'h1);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        #1;
        chk("ch0_pend_hold", 32'(pend_o[0]), 32'h1);
        cseq = '0; tseq = '0;
        for (int k = 0; k < 11; k++) begin
            #1;
            if (k == 4) chk("ch0_pend_clr", 32'(pend_o[0]), 32'h0);
            cseq = {cseq[10:0], clk_o[0]};
            tseq = {tseq[10:0], tick_o[0]};
            @(negedge clk);
        end
        chk("ch0_clk_seq", 32'(cseq), 32'h187);
        chk("ch0_tick_seq", 32'(tseq), 32'h081);

        // Mixed periods 3,4,6,1 plus ignored out-of-range writes; realign with sync.
        cfg(1'b1, 3'd5, 16'd2);
        @(negedge clk);
        cfg(1'b1, 3'd7, 16'd9);
        @(negedge clk);
        cfg(1'b1, 3'd0, 16'd3);
        @(negedge clk);
        cfg(1'b1, 3'd3, 16'd1);
        @(negedge clk);
        cfg(1'b1, 3'd2, 16'd6);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        #1;
        chk("mix_pend_a", 32'(pend_o), 32'h0d);
        @(negedge clk);
        #1;
        chk("mix_pend_b", 32'(pend_o), 32'h09);
        @(negedge clk);
        #1;
        chk("mix_pend_c", 32'(pend_o), 32'h08);
        sync = 1'b1;
        #1;
        chk("sync2_tick", 32'(tick_o), 32'h0);
        @(negedge clk);
        sync = 1'b0;
        #1;
        chk("sync2_pend", 32'(pend_o), 32'h0);
        chk("sync2_clk", 32'(clk_o), 32'h0);
        for (int z = 0; z < 15; z++) begin
            #1;
            if (z == 0)  chk("mix_tick_z0", 32'(tick_o), 32'h08);
            if (z == 2)  chk("mix_tick_z2", 32'(tick_o), 32'h09);
            if (z == 3)  chk("mix_tick_z3", 32'(tick_o), 32'h0a);
            if (z == 5)  chk("mix_tick_z5", 32'(tick_o), 32'h0d);
            if (z == 11) chk("mix_tick_z11", 32'(tick_o), 32'h0f);
            if (z == 2)  chk("mix_clk_z2", 32'(clk_o), 32'h03);
            if (z == 3)  chk("mix_clk_z3", 32'(clk_o), 32'h06);
            @(negedge clk);
        end

        // en low for 10 cycles: levels hold, no ticks, period stretched by 10.
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            en = 1'b0;
            #1;
            if (tick_o != 5'h0) bad++;
            if (clk_o != 5'h06) bad++;
            @(negedge clk);
        end
        chk("en_hold", 32'(bad), 32'h0);
        en = 1'b1;
        #1;
        chk("en_resume_tick", 32'(tick_o), 32'h0a);
        @(negedge clk);
        cfg(1'b1, 3'd4, 16'd2);
        #1;
        chk("en_ch2_no_tick", 32'(tick_o[2]), 32'h0);
        @(negedge clk);
        cfg(1'b0, 3'd0, 16'd0);
        #1;
        chk("en_ch2_tick", 32'(tick_o[2]), 32'h1);
        chk("pre_rst_clk", 32'(clk_o), 32'h05);
        chk("pre_rst_pend", 32'(pend_o), 32'h10);

        // Asynchronous reset mid-period, before the next clock edge.
        reset = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_o), 32'h0);
        chk("arst_tick", 32'(tick_o), 32'h0);
        chk("arst_pend", 32'(pend_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        acc = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            acc = acc | tick_o | clk_o | pend_o;
            @(negedge clk);
        end
        chk("post_rst_quiet", 32'(acc), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
